// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle MIPS main controller with ready-handshaked memory
//               and a retired-instruction counter. Optional macro
//               ILLEGAL_OP_TRAP_EN traps unknown opcodes in a sticky TRAP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_2_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal_op
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EXEC = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;
  localparam logic [3:0] S_TRAP      = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             unknown_op;

  always_comb begin
    state_d    = state_q;
    unknown_op = 1'b0;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          default: begin
            unknown_op = 1'b1;
`ifdef ILLEGAL_OP_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
  end

  // Retirement is any return to FETCH, except the trap exit (only rst leaves TRAP).
  always_comb begin
    count_d = count_q;
    if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_TRAP)
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q | unknown_op;
  end

  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  logic pc_write_s, pc_write_cond_s, mem_read_s, mem_write_s, ir_write_s, reg_write_s;

  always_comb begin
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    reg_write_s     = 1'b0;
    i_or_d          = 1'b0;
    mem_2_reg       = 1'b0;
    reg_dst         = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    alu_op          = 2'b00;
    pc_source       = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read_s = 1'b1;
        alu_src_b  = 2'b01;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
      end
      S_DECODE:    alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        i_or_d     = 1'b1;
        mem_read_s = 1'b1;
      end
      S_MEM_WB: begin
        mem_2_reg   = 1'b1;
        reg_write_s = 1'b1;
      end
      S_MEM_WRITE: begin
        i_or_d      = 1'b1;
        mem_write_s = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_dst     = 1'b1;
        reg_write_s = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a       = 1'b1;
        alu_op          = 2'b01;
        pc_write_cond_s = 1'b1;
        pc_source       = 2'b01;
      end
      S_JUMP: begin
        pc_write_s = 1'b1;
        pc_source  = 2'b10;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB:   reg_write_s = 1'b1;
      default: ;
    endcase
  end

  // Strobes are suppressed combinationally so nothing fires during reset.
  assign pc_write      = pc_write_s      & ~rst;
  assign pc_write_cond = pc_write_cond_s & ~rst;
  assign mem_read      = mem_read_s      & ~rst;
  assign mem_write     = mem_write_s     & ~rst;
  assign ir_write      = ir_write_s      & ~rst;
  assign reg_write     = reg_write_s     & ~rst;
  assign state_o       = state_q;
  assign instr_count   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Scoreboard bench for multicycle_ctrl; directed vectors with
//               hand-computed state/count, control table as reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  localparam logic [3:0] FE = 4'd0,  DE = 4'd1,  MA = 4'd2,  MR = 4'd3;
  localparam logic [3:0] MW = 4'd4,  MX = 4'd5,  RE = 4'd6,  RW = 4'd7;
  localparam logic [3:0] BR = 4'd8,  JP = 4'd9,  AE = 4'd10, AW = 4'd11;
  localparam logic [3:0] TR = 4'd12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'h00;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_2_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state_o;
  logic [31:0] instr_count;
  logic        illegal_op;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_2_reg(mem_2_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state_o(state_o), .instr_count(instr_count),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic [31:0] cnt;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [15:0] act_ctrl;
  assign act_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  // Control table: {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca, srcb, aluop, pcsrc}
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic rdy, input logic r);
    logic [15:0] c;
    case (st)
      FE: c = {rdy, 1'b0, 1'b0, 1'b1, 1'b0, rdy, 4'b0000, 2'b01, 2'b00, 2'b00};
      DE: c = {10'b0000000000, 2'b11, 2'b00, 2'b00};
      MA: c = {9'b000000000, 1'b1, 2'b10, 2'b00, 2'b00};
      MR: c = {2'b00, 1'b1, 1'b1, 6'b000000, 6'b000000};
      MW: c = {6'b000000, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000000};
      MX: c = {2'b00, 1'b1, 1'b0, 1'b1, 5'b00000, 6'b000000};
      RE: c = {9'b000000000, 1'b1, 2'b00, 2'b10, 2'b00};
      RW: c = {7'b0000000, 1'b1, 1'b1, 1'b0, 6'b000000};
      BR: c = {1'b0, 1'b1, 7'b0000000, 1'b1, 2'b00, 2'b01, 2'b01};
      JP: c = {1'b1, 13'b0, 2'b10};
      AE: c = {9'b000000000, 1'b1, 2'b10, 2'b00, 2'b00};
      AW: c = {8'b00000000, 1'b1, 1'b0, 6'b000000};
      default: c = 16'h0000;
    endcase
    if (r) c = c & 16'b0110_0011_1011_1111 & 16'b1011_1111_1111_1111
               & 16'b1111_1011_1111_1111 & 16'b0111_1111_1111_1111;
    return c;
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show during it.
  task automatic step(input logic [5:0] op, input logic rdy, input logic r,
                      input logic [3:0] st, input logic [31:0] cnt, input logic ill);
    exp_t e;
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = rdy;
    rst       = r;
    e.st   = st;
    e.ctrl = exp_ctrl(st, rdy, r);
    e.cnt  = cnt;
    e.ill  = ill;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (state_o !== e.st) begin
        errors++;
        $display("FAIL state: got %0d expected %0d at %0t", state_o, e.st, $time);
      end
      checks++;
      if (act_ctrl !== e.ctrl) begin
        errors++;
        $display("FAIL ctrl: got %b expected %b (state %0d) at %0t", act_ctrl, e.ctrl, e.st, $time);
      end
      checks++;
      if (instr_count !== e.cnt) begin
        errors++;
        $display("FAIL instr_count: got %0d expected %0d at %0t", instr_count, e.cnt, $time);
      end
      checks++;
      if (illegal_op !== e.ill) begin
        errors++;
        $display("FAIL illegal_op: got %b expected %b at %0t", illegal_op, e.ill, $time);
      end
      checks++;
      if (mem_read === 1'b1 && mem_write === 1'b1) begin
        errors++;
        $display("FAIL mem_excl: got rd=%b wr=%b expected not both at %0t", mem_read, mem_write, $time);
      end
    end
  end

  initial begin
    // Reset and R-type
    step(6'h00, 1'b1, 1'b1, FE, 0, 1'b0);
    step(6'h00, 1'b1, 1'b0, FE, 0, 1'b0);
    step(6'h00, 1'b1, 1'b0, DE, 0, 1'b0);
    step(6'h00, 1'b1, 1'b0, RE, 0, 1'b0);
    step(6'h00, 1'b1, 1'b0, RW, 0, 1'b0);
    step(6'h23, 1'b1, 1'b0, FE, 1, 1'b0);
    // LW with two wait cycles in MEM_READ
    step(6'h23, 1'b1, 1'b0, DE, 1, 1'b0);
    step(6'h23, 1'b1, 1'b0, MA, 1, 1'b0);
    step(6'h23, 1'b0, 1'b0, MR, 1, 1'b0);
    step(6'h23, 1'b0, 1'b0, MR, 1, 1'b0);
    step(6'h23, 1'b1, 1'b0, MR, 1, 1'b0);
    step(6'h23, 1'b1, 1'b0, MW, 1, 1'b0);
    step(6'h2B, 1'b1, 1'b0, FE, 2, 1'b0);
    // SW, BEQ, J zero-wait
    step(6'h2B, 1'b1, 1'b0, DE, 2, 1'b0);
    step(6'h2B, 1'b1, 1'b0, MA, 2, 1'b0);
    step(6'h2B, 1'b1, 1'b0, MX, 2, 1'b0);
    step(6'h04, 1'b1, 1'b0, FE, 3, 1'b0);
    step(6'h04, 1'b1, 1'b0, DE, 3, 1'b0);
    step(6'h04, 1'b1, 1'b0, BR, 3, 1'b0);
    step(6'h02, 1'b1, 1'b0, FE, 4, 1'b0);
    step(6'h02, 1'b1, 1'b0, DE, 4, 1'b0);
    step(6'h02, 1'b1, 1'b0, JP, 4, 1'b0);
    // FETCH held by memory for three cycles
    step(6'h00, 1'b0, 1'b0, FE, 5, 1'b0);
    step(6'h00, 1'b0, 1'b0, FE, 5, 1'b0);
    step(6'h00, 1'b0, 1'b0, FE, 5, 1'b0);
    step(6'h2B, 1'b1, 1'b0, FE, 5, 1'b0);
    // SW interrupted by reset while waiting
    step(6'h2B, 1'b1, 1'b0, DE, 5, 1'b0);
    step(6'h2B, 1'b1, 1'b0, MA, 5, 1'b0);
    step(6'h2B, 1'b0, 1'b0, MX, 5, 1'b0);
    step(6'h2B, 1'b0, 1'b1, MX, 5, 1'b0);
    step(6'h08, 1'b1, 1'b0, FE, 0, 1'b0);
    // ADDI
    step(6'h08, 1'b1, 1'b0, DE, 0, 1'b0);
    step(6'h08, 1'b1, 1'b0, AE, 0, 1'b0);
    step(6'h08, 1'b1, 1'b0, AW, 0, 1'b0);
    step(6'h3F, 1'b1, 1'b0, FE, 1, 1'b0);
    // Unknown opcode 0x3F
    step(6'h3F, 1'b1, 1'b0, DE, 1, 1'b0);
`ifdef ILLEGAL_OP_TRAP_EN
    for (int i = 0; i < 10; i++) step(6'h00, 1'b1, 1'b0, TR, 1, 1'b1);
    step(6'h00, 1'b1, 1'b1, TR, 1, 1'b1);
    step(6'h00, 1'b1, 1'b0, FE, 0, 1'b0);
`else
    step(6'h00, 1'b1, 1'b0, FE, 2, 1'b0);
    step(6'h00, 1'b1, 1'b0, DE, 2, 1'b0);
    step(6'h00, 1'b1, 1'b0, RE, 2, 1'b0);
`endif
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
